aes_pnm_job_arbiter: RTL
========================

AES_PNM_JOB_ARBITER -- requirements
Module: aes_pnm_job_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one AES PNM engine (2..8).
REQ-002 Parameter TO_CYCLES, default 1023, engine watchdog limit in clock cycles.
REQ-003 clk  input  1  single clock; all logic on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  N_REQ  per-requester job request, level.
REQ-006 req_enc_dec  input  N_REQ  per-requester mode: 1 = encrypt, 0 = decrypt.
REQ-007 req_ready  output  N_REQ  one-hot, one-cycle accept pulse.
REQ-008 rsp_valid  output  N_REQ  one-hot, one-cycle completion pulse.
REQ-009 rsp_err  output  1  timeout flag, meaningful only while any rsp_valid bit is high.
REQ-010 eng_start  output  1  one-cycle engine start pulse.
REQ-011 eng_enc_dec  output  1  engine mode, held stable from eng_start until the response.
REQ-012 eng_done  input  1  engine completion pulse.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 cur_id  output  clog2(N_REQ)  index of the granted requester.

Function
REQ-015 The FSM SHALL have four states: IDLE, START, RUN, RESP.
REQ-016 IDLE, any req_valid high:
- Select the winner round-robin, searching from last_id+1 upward with wrap.
- Assert req_ready[winner] in the same cycle.
- Register cur_id <= winner and eng_enc_dec <= req_enc_dec[winner].
- Go to START.
REQ-017 IDLE, no req_valid: remain in IDLE with all pulse outputs low.
REQ-018 START: assert eng_start for exactly one cycle, clear the watchdog counter, go to RUN.
REQ-019 RUN: increment the watchdog counter every cycle.
- eng_done high: go to RESP with error = 0.
- Otherwise, counter == TO_CYCLES-1: go to RESP with error = 1.
REQ-020 When eng_done and the watchdog expiry occur in the same cycle, done SHALL win and error = 0.
REQ-021 eng_done SHALL be ignored in IDLE, START and RESP.
REQ-022 RESP:
- Assert rsp_valid[cur_id] for one cycle, with rsp_err = error.
- Update last_id <= cur_id.
- Go to IDLE.
REQ-023 Latency:
- req_valid sampled in IDLE at cycle T gives req_ready at T and eng_start at T+1.
- eng_done at cycle D gives rsp_valid at D+1.
- The next grant occurs no earlier than D+2.
REQ-024 Only one job SHALL be outstanding at any time; req_ready SHALL never be asserted outside IDLE.
REQ-025 A requester that drops req_valid before it is accepted SHALL lose its turn, with no side effects.
REQ-026 A requester may hold req_valid high continuously. It SHALL be re-granted only after all other active requesters have been served once (fairness bound: N_REQ jobs).
REQ-027 The watchdog counter SHALL be wide enough to hold TO_CYCLES-1 and SHALL saturate; it SHALL never wrap.

Reset
REQ-028 On rst_n low, the block SHALL asynchronously enter IDLE and drive the following to 0: req_ready, rsp_valid, rsp_err, eng_start, eng_enc_dec, busy, cur_id, watchdog counter.
REQ-029 On reset, last_id SHALL be set to N_REQ-1, so requester 0 has first priority.
REQ-030 Reset during START, RUN or RESP SHALL discard the job; no rsp_valid is issued for it.

Structure
REQ-031 State encodings and the N_REQ / TO_CYCLES defaults SHALL live in the shared package aes_pnm_pkg.
REQ-032 Winner selection SHALL be a combinational sub-module, aes_pnm_rr_arb.
- Inputs: request vector, last_id.
- Outputs: one-hot grant, index, any-request flag.

Verification
REQ-033 Single request: req_valid=4'b0100, enc=1 -> req_ready=4'b0100 in the same cycle; eng_start next cycle with eng_enc_dec=1; eng_done 50 cycles later -> rsp_valid=4'b0100 one cycle later, rsp_err=0.
REQ-034 Fairness: req_valid=4'b1111 held, engine done after 10 cycles each time -> grants in order 0,1,2,3,0; each job completes with exactly one rsp pulse.
REQ-035 Timeout: TO_CYCLES=16, eng_done never asserted -> rsp_valid at 17 cycles after eng_start with rsp_err=1, then IDLE.
REQ-036 Collision: TO_CYCLES=16, eng_done coincident with the expiry cycle -> rsp_err=0.
REQ-037 Mid-job reset: rst_n low during RUN -> all outputs 0 immediately; no rsp_valid after release; the next grant goes to requester 0 when req_valid=4'b1111.
REQ-038 Withdrawn request: requester 1 asserts during RUN and drops before RESP -> it receives no req_ready, and a stray eng_done in IDLE produces no response.

Source files
------------

// File: rtl/aes_pnm_pkg.sv
// ============================================================================
// Module      : aes_pnm_pkg
// Description : Shared defaults and FSM state encoding for the AES PNM arbiter
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_pnm_pkg;

    localparam int N_REQ_DEFAULT     = 4;
    localparam int TO_CYCLES_DEFAULT = 1023;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/aes_pnm_rr_arb.sv
// ============================================================================
// Module      : aes_pnm_rr_arb
// Description : Combinational round-robin winner select, searching upward
//               from last_id_i+1 with wrap
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_pnm_rr_arb
    import aes_pnm_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT
) (
    input  logic [N_REQ-1:0]         req_i,
    input  logic [$clog2(N_REQ)-1:0] last_id_i,
    output logic [N_REQ-1:0]         grant_o,
    output logic [$clog2(N_REQ)-1:0] idx_o,
    output logic                     any_o
);

    localparam int IW = $clog2(N_REQ);

    logic          found_w;
    logic [IW-1:0] cand_w;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found_w = 1'b0;
        cand_w  = '0;
        // i = N_REQ revisits last_id itself, so a lone requester still wins
        for (int i = 1; i <= N_REQ; i++) begin
            cand_w = IW'((int'(last_id_i) + i) % N_REQ);
            if (!found_w && req_i[cand_w]) begin
                found_w         = 1'b1;
                grant_o[cand_w] = 1'b1;
                idx_o           = cand_w;
            end
        end
    end

    assign any_o = |req_i;

endmodule

`default_nettype wire

// File: rtl/aes_pnm_job_arbiter.sv
// ============================================================================
// Module      : aes_pnm_job_arbiter
// Description : Shares one AES PNM engine among N_REQ requesters, one job at
//               a time, with round-robin grant and an engine watchdog
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_pnm_job_arbiter
    import aes_pnm_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEFAULT,
    parameter int TO_CYCLES = TO_CYCLES_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ-1:0]         req_enc_dec,
    output logic [N_REQ-1:0]         req_ready,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic                     rsp_err,
    output logic                     eng_start,
    output logic                     eng_enc_dec,
    input  logic                     eng_done,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] cur_id
);

    localparam int            IW      = $clog2(N_REQ);
    localparam int            CW      = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
    localparam logic [CW-1:0] WD_LAST = CW'(TO_CYCLES - 1);

    state_e        state_q, state_d;
    logic [IW-1:0] cur_id_q, cur_id_d;
    logic [IW-1:0] last_id_q, last_id_d;
    logic          enc_q, enc_d;
    logic          err_q, err_d;
    logic [CW-1:0] wd_q, wd_d;

    logic [N_REQ-1:0] grant_w;
    logic [IW-1:0]    win_idx_w;
    logic             any_req_w;

    aes_pnm_rr_arb #(
        .N_REQ (N_REQ)
    ) u_rr_arb (
        .req_i     (req_valid),
        .last_id_i (last_id_q),
        .grant_o   (grant_w),
        .idx_o     (win_idx_w),
        .any_o     (any_req_w)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cur_id_q  <= '0;
            last_id_q <= IW'(N_REQ - 1);
            enc_q     <= 1'b0;
            err_q     <= 1'b0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            cur_id_q  <= cur_id_d;
            last_id_q <= last_id_d;
            enc_q     <= enc_d;
            err_q     <= err_d;
            wd_q      <= wd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_id_d  = cur_id_q;
        last_id_d = last_id_q;
        enc_d     = enc_q;
        err_d     = err_q;
        wd_d      = wd_q;
        req_ready = '0;
        rsp_valid = '0;
        rsp_err   = 1'b0;
        eng_start = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (any_req_w) begin
                    req_ready = grant_w;
                    cur_id_d  = win_idx_w;
                    enc_d     = req_enc_dec[win_idx_w];
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                eng_start = 1'b1;
                wd_d      = '0;
                err_d     = 1'b0;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                if (wd_q != WD_LAST) begin
                    wd_d = wd_q + 1'b1;
                end
                // done takes priority over a coincident watchdog expiry
                if (eng_done) begin
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (wd_q == WD_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid[cur_id_q] = 1'b1;
                rsp_err             = err_q;
                last_id_d           = cur_id_q;
                state_d             = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign eng_enc_dec = enc_q;
    assign busy        = (state_q != ST_IDLE);
    assign cur_id      = cur_id_q;

endmodule

`default_nettype wire
